// File: rtl/if_id_pipe.sv
// rtl/if_id_pipe.sv - IF/ID stage register with valid/ready handshake, flush and stall counter
// Define IF_ID_SKID_BUF_EN to add a skid entry and make o_ready a flop output.
module if_id_pipe #(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h0000_0013),
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [ILEN-1:0]  i_instr,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_pc,
  output logic [ILEN-1:0]  o_instr,
  output logic [CNT_W-1:0] o_stall_cnt
);

  logic             valid_q;
  logic [XLEN-1:0]  pc_q;
  logic [ILEN-1:0]  instr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             acc;
  logic             take;

  assign o_valid     = valid_q;
  assign o_pc        = pc_q;
  assign o_instr     = instr_q;
  assign o_stall_cnt = cnt_q;

  assign acc  = i_valid && o_ready;
  assign take = valid_q && i_ready;

  // Counts back-pressured cycles; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (valid_q && !i_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef IF_ID_SKID_BUF_EN
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  state_t          state_q, state_d;
  logic            ready_q;
  logic [XLEN-1:0] skid_pc_q;
  logic [ILEN-1:0] skid_instr_q;
  logic            load_in, load_skid, move_skid, drop_main;

  assign o_ready = ready_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != SKID);
      valid_q <= (state_d != EMPTY);
    end
  end

  always_comb begin
    state_d   = state_q;
    load_in   = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    drop_main = 1'b0;
    if (i_flush) begin
      state_d   = EMPTY;
      drop_main = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = FULL;
            load_in = 1'b1;
          end
        end
        FULL: begin
          if (acc && take) begin
            load_in = 1'b1;
          end else if (take) begin
            state_d   = EMPTY;
            drop_main = 1'b1;
          end else if (acc) begin
            state_d   = SKID;
            load_skid = 1'b1;
          end
        end
        SKID: begin
          if (take) begin
            state_d   = FULL;
            move_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else if (load_in) begin
      pc_q    <= i_pc;
      instr_q <= i_instr;
    end else if (move_skid) begin
      pc_q    <= skid_pc_q;
      instr_q <= skid_instr_q;
    end else if (drop_main) begin
      instr_q <= NOP_INSTR;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else if (load_skid) begin
      skid_pc_q    <= i_pc;
      skid_instr_q <= i_instr;
    end
  end
`else
  assign o_ready = !valid_q || i_ready;

  // pc_q is left untouched when the entry drains or is flushed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else if (i_flush) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (acc) begin
      valid_q <= 1'b1;
      pc_q    <= i_pc;
      instr_q <= i_instr;
    end else if (take) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// tb/tb_if_id_pipe.sv - self-checking bench for if_id_pipe with a queue-based reference model
module tb_if_id_pipe;

`ifdef IF_ID_SKID_BUF_EN
  localparam bit SKID_BUILD = 1'b1;
`else
  localparam bit SKID_BUILD = 1'b0;
`endif
  localparam int CNT_W = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [31:0]      i_pc = '0;
  logic [31:0]      i_instr = '0;
  logic             i_flush = 1'b0;
  logic             o_valid;
  logic             i_ready = 1'b0;
  logic [31:0]      o_pc;
  logic [31:0]      o_instr;
  logic [CNT_W-1:0] o_stall_cnt;

  int total = 0;
  int bad = 0;

  logic [31:0] q_pc[$];
  logic [31:0] q_in[$];
  logic [31:0] last_pc;
  int          exp_cnt;

  if_id_pipe #(.XLEN(32), .ILEN(32), .NOP_INSTR(32'h0000_0013), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .o_ready(o_ready), .i_pc(i_pc),
    .i_instr(i_instr), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_pc(o_pc), .o_instr(o_instr), .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  // A one-entry buffer (two with the skid) in front of decode.
  function automatic bit model_ready();
    if (SKID_BUILD) return q_pc.size() < 2;
    return (q_pc.size() == 0) || i_ready;
  endfunction

  task automatic model_reset();
    q_pc.delete();
    q_in.delete();
    last_pc = '0;
    exp_cnt = 0;
  endtask

  task automatic tick();
    bit acc, take;
    acc  = i_valid && model_ready();
    take = (q_pc.size() > 0) && i_ready;
    if ((q_pc.size() > 0) && !i_ready && exp_cnt < CMAX) exp_cnt++;
    if (i_flush) begin
      q_pc.delete();
      q_in.delete();
    end else begin
      if (take) begin
        void'(q_pc.pop_front());
        void'(q_in.pop_front());
      end
      if (acc) begin
        q_pc.push_back(i_pc);
        q_in.push_back(i_instr);
      end
    end
    if (q_pc.size() > 0) last_pc = q_pc[0];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    i_valid = 1'b1;
    i_ready = 1'b1;
    i_pc = 32'h100;
    i_instr = 32'hABCD_0001;
    model_reset();
    #12;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    total++; if (o_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", o_pc); end
    total++; if (o_instr !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", o_instr, NOP); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    total++; if (o_stall_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", o_stall_cnt); end
    @(negedge clk);
    rstn = 1'b1;
    tick();
    total++; if (o_pc !== 32'h100 || o_valid !== 1'b1) begin
      bad++; $display("FAIL reset_release got pc=%h v=%b exp pc=100 v=1", o_pc, o_valid);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    i_ready = 1'b1;
    i_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_pc = 32'(4 * k);
      i_instr = 32'h5000_0000 + 32'(k);
      tick();
      total++; if (o_valid !== 1'b1 || o_pc !== 32'(4 * k) || o_instr !== 32'h5000_0000 + 32'(k)) begin
        bad++; $display("FAIL stream_%0d got pc=%h v=%b exp pc=%h v=1", k, o_pc, o_valid, 4 * k);
      end
    end
    total++; if (o_stall_cnt !== '0) begin bad++; $display("FAIL stream_cnt got=%0d exp=0", o_stall_cnt); end
    i_valid = 1'b0;
  endtask

  task automatic test_back_pressure();
    logic [31:0] got[$];
    int idx = 0;
    int cyc = 0;
    bit acc_now;
    do_reset();
    while (got.size() < 4 && cyc < 30) begin
      i_ready = !(cyc >= 2 && cyc <= 4);
      i_valid = (idx < 4);
      i_pc = 32'(4 * idx);
      i_instr = 32'h7000_0000 + 32'(4 * idx);
      #1;
      if (cyc == 2) begin
        total++; if (o_ready !== SKID_BUILD) begin
          bad++; $display("FAIL bp_ready_first got=%b exp=%b", o_ready, SKID_BUILD);
        end
      end
      if (cyc == 3) begin
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_held got=%b exp=0", o_ready); end
      end
      if (o_valid && i_ready) begin
        got.push_back(o_pc);
        total++; if (o_instr !== 32'h7000_0000 + o_pc) begin
          bad++; $display("FAIL bp_instr got=%h exp=%h", o_instr, 32'h7000_0000 + o_pc);
        end
      end
      acc_now = i_valid && o_ready;
      tick();
      if (acc_now) idx++;
      cyc++;
    end
    total++; if (got.size() != 4) begin
      bad++; $display("FAIL bp_timeout got=%0d entries exp=4", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      total++; if (got[k] !== 32'(4 * k)) begin bad++; $display("FAIL bp_order_%0d got=%h exp=%h", k, got[k], 4 * k); end
    end
    total++; if (o_stall_cnt !== 4'd3) begin bad++; $display("FAIL bp_cnt got=%0d exp=3", o_stall_cnt); end
    i_valid = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_pc = 32'h10; i_instr = 32'h1111_0000;
    tick();
    i_pc = 32'h14; i_instr = 32'h1111_0004;
    tick();
    i_flush = 1'b1;
    i_pc = 32'h200; i_instr = 32'h2222_0000;
    tick();
    i_flush = 1'b0;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", o_valid); end
    total++; if (o_instr !== NOP) begin bad++; $display("FAIL flush_instr got=%h exp=%h", o_instr, NOP); end
    total++; if (o_pc !== 32'h10) begin bad++; $display("FAIL flush_pc_hold got=%h exp=10", o_pc); end
    total++; if (o_stall_cnt !== 4'd2) begin bad++; $display("FAIL flush_cnt got=%0d exp=2", o_stall_cnt); end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
        bad++; $display("FAIL flush_drain_%0d got v=%b r=%b pc=%h exp v=0 r=1", k, o_valid, o_ready, o_pc);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_pc = 32'h40; i_instr = 32'h4444_0000;
    tick();
    i_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 10 || k == 15 || k == 20) begin
        total++; if (o_stall_cnt !== CNT_W'((k < CMAX) ? k : CMAX)) begin
          bad++; $display("FAIL sat_%0d got=%0d exp=%0d", k, o_stall_cnt, (k < CMAX) ? k : CMAX);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_pc = 32'h50; i_instr = 32'h5555_0000;
    tick();
    i_pc = 32'h54; i_instr = 32'h5555_0004;
    tick();
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    total++; if (o_valid !== 1'b0 || o_instr !== NOP || o_pc !== 32'h0 || o_stall_cnt !== '0) begin
      bad++; $display("FAIL areset_clear got v=%b pc=%h instr=%h cnt=%0d exp v=0 pc=0 instr=13 cnt=0",
                      o_valid, o_pc, o_instr, o_stall_cnt);
    end
    @(negedge clk);
    rstn = 1'b1;
    i_valid = 1'b1;
    i_ready = 1'b1;
    i_pc = 32'h300; i_instr = 32'h3333_0000;
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL areset_ready got=%b exp=1", o_ready); end
    tick();
    total++; if (o_valid !== 1'b1 || o_pc !== 32'h300) begin
      bad++; $display("FAIL areset_fresh got pc=%h v=%b exp pc=300 v=1", o_pc, o_valid);
    end
    i_valid = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      i_valid = $urandom_range(0, 3) != 0;
      i_ready = $urandom_range(0, 2) != 0;
      i_flush = $urandom_range(0, 15) == 0;
      i_pc = $urandom & 32'hFFFF_FFFC;
      i_instr = $urandom;
      #1;
      total++; if (o_valid !== (q_pc.size() > 0)) begin
        bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, o_valid, q_pc.size() > 0);
      end
      total++; if (o_ready !== model_ready()) begin
        bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", n, o_ready, model_ready());
      end
      if (q_pc.size() > 0) begin
        total++; if (o_pc !== q_pc[0] || o_instr !== q_in[0]) begin
          bad++; $display("FAIL rnd_head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h", n, o_pc, o_instr, q_pc[0], q_in[0]);
        end
      end else begin
        total++; if (o_pc !== last_pc || o_instr !== NOP) begin
          bad++; $display("FAIL rnd_idle cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h", n, o_pc, o_instr, last_pc, NOP);
        end
      end
      total++; if (o_stall_cnt !== CNT_W'(exp_cnt)) begin
        bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", n, o_stall_cnt, exp_cnt);
      end
      tick();
    end
    i_flush = 1'b0;
    i_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_saturation();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_pipe.md
# if_id_pipe

Parametrised IF/ID pipeline stage register with a valid/ready handshake, synchronous flush, NOP bubble insertion and a saturating stall counter. It sits between the fetch unit and the decoder and replaces the free-running PC/instruction register. It lets decode back-pressure fetch and lets branch resolution squash the in-flight instruction. An optional skid buffer makes the upstream ready a pure register output for timing closure.

## Interface
- XLEN, 32: PC width in bits.
- ILEN, 32: instruction width in bits.
- NOP_INSTR, 32'h0000_0013: bubble encoding (addi x0,x0,0), ILEN bits wide.
- CNT_W, 16: stall counter width.
- clk  input  1  clock, all state updates on rising edge.
- rstn  input  1  asynchronous, active-low reset.
- i_valid  input  1  fetch presents a valid PC/instruction.
- o_ready  output  1  stage can accept; transfer when i_valid && o_ready.
- i_pc  input  XLEN  fetched PC.
- i_instr  input  ILEN  fetched instruction.
- i_flush  input  1  squash everything held; highest priority.
- o_valid  output  1  decode-side entry valid.
- i_ready  input  1  decode accepts; transfer when o_valid && i_ready.
- o_pc  output  XLEN  held PC.
- o_instr  output  ILEN  held instruction, NOP_INSTR when no valid entry.
- o_stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

## Operation
- Main register (valid, pc, instr) drives outputs directly; no combinational path from inputs to o_pc/o_instr/o_valid.
- Upstream accept (acc) = i_valid && o_ready; downstream take (take) = o_valid && i_ready.
- Without skid: o_ready = !o_valid || i_ready (combinational from i_ready). On acc, the main register loads the inputs. On take without acc, o_valid clears and o_instr becomes NOP_INSTR, while o_pc holds its value. On acc and take in the same cycle, the new entry loads and throughput is 1 per cycle.
- With skid: three states, EMPTY, FULL and SKID. o_ready = (state != SKID), and it is a flop output.
  - EMPTY -> FULL on acc.
  - FULL: acc && take -> FULL, main reloaded with the new entry.
  - FULL: take only -> EMPTY.
  - FULL: acc only -> SKID, input captured into the skid register.
  - SKID: take -> FULL, skid moved into main. No acc is possible in SKID.
- Flush: on i_flush, the next state is EMPTY. o_valid = 0, o_instr = NOP_INSTR, the skid entry is discarded and o_pc holds. Any input accepted in the flush cycle is dropped. Flush overrides acc and take, although a take in the flush cycle still completes from decode's view.
- Stall counter: increments by 1 each cycle with o_valid && !i_ready. It saturates at 2^CNT_W-1 with no wrap. It is cleared only by reset and is unaffected by flush.
- Reset (async assert, sync-safe deassert expected externally): o_valid = 0, o_pc = 0, o_instr = NOP_INSTR, o_stall_cnt = 0, state EMPTY. o_ready = 1 after reset.

## Timing
- Latency input -> output: 1 cycle, both modes.
- Throughput: 1 entry per cycle under continuous i_ready, both modes.
- Without skid, o_ready depends combinationally on i_ready. With skid, o_ready responds 1 cycle after back-pressure, and the skid absorbs the one extra beat.
- Flush takes effect at the next edge. o_valid is 0 in the cycle after i_flush regardless of i_valid.
- Reset mid-operation clears all entries immediately and asynchronously. No partial transfer survives.

## Configuration
- IF_ID_SKID_BUF_EN defined: skid register and EMPTY/FULL/SKID state machine compiled in, with a registered o_ready.
- IF_ID_SKID_BUF_EN undefined: single register, combinational o_ready = !o_valid || i_ready, and no skid storage.
- Port list and all other behaviour are identical in both builds.

## Test plan
- Reset: hold rstn=0 with i_valid=1 and i_pc=32'h100. Expect o_valid=0, o_pc=0, o_instr=32'h13, o_ready=1 and o_stall_cnt=0. Release, and one cycle later o_pc=32'h100 appears.
- Streaming: i_valid=1 and i_ready=1 with PCs 0x0, 0x4, 0x8, 0xC on consecutive cycles. Expect each to appear on o_pc exactly 1 cycle later with no bubbles, and o_stall_cnt stays 0.
- Back-pressure: drop i_ready for 3 cycles mid-stream. Expect no entry lost or duplicated, o_stall_cnt=3, and output order 0x0, 0x4, 0x8, 0xC preserved. With IF_ID_SKID_BUF_EN, o_ready falls 1 cycle after i_ready falls and the skid holds one entry.
- Flush: assert i_flush while o_valid=1 (and skid full in the skid build) with i_valid=1 and i_pc=32'h200. Next cycle expect o_valid=0, o_instr=32'h13 and PC 0x200 never presented.
- Saturation: CNT_W=4, hold o_valid=1 and i_ready=0 for 20 cycles. Expect o_stall_cnt reaches 15 and stays there.
- Async reset mid-stall: assert rstn=0 between edges while the skid is full. Expect o_valid=0 immediately, and after release a fresh entry is accepted with o_ready=1.
